// File: rtl/aes_inv_mixcolumns_wddl_seq_pkg.sv
// ============================================================================
// Package : aes_wddl_pkg
// Shared WDDL dual-rail AES types, constants and dual-rail GF(2^8) helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_wddl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NUM_COLS = 4;
  localparam int         COL_W    = 32;
  localparam int         BYTE_W   = 8;
  localparam int         BLOCK_W  = 128;
  localparam logic [1:0] LAST_COL = 2'd3;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] n;
  } dr_byte_t;

  // WDDL XOR: both output rails are monotone in the input rails, so an
  // all-zero precharge on the inputs yields all-zero on the outputs.
  function automatic dr_byte_t dr_xor(dr_byte_t a, dr_byte_t b);
    dr_byte_t r;
    r.p = (a.p & b.n) | (a.n & b.p);
    r.n = (a.p & b.p) | (a.n & b.n);
    return r;
  endfunction

  // Dual-rail xtime: reduction bits XOR in a7, the rest are pure wiring.
  function automatic dr_byte_t dr_xtime(dr_byte_t a);
    dr_byte_t r;
    r.p[0] = a.p[7];
    r.n[0] = a.n[7];
    for (int i = 1; i < 8; i++) begin
      if (AES_POLY[i]) begin
        r.p[i] = (a.p[i-1] & a.n[7]) | (a.n[i-1] & a.p[7]);
        r.n[i] = (a.p[i-1] & a.p[7]) | (a.n[i-1] & a.n[7]);
      end else begin
        r.p[i] = a.p[i-1];
        r.n[i] = a.n[i-1];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_mixcolumns_wddl_seq_if.sv
// ============================================================================
// Interface : aes_inv_mixcolumns_wddl_seq_if
// Dual-rail block input and result handshake bundle.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface aes_inv_mixcolumns_wddl_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_p;
  logic [127:0] in_n;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_p;
  logic [127:0] out_n;

  modport master (
    output in_valid, in_p, in_n, out_ready,
    input  in_ready, out_valid, out_p, out_n
  );

  modport slave (
    input  in_valid, in_p, in_n, out_ready,
    output in_ready, out_valid, out_p, out_n
  );
endinterface

`default_nettype wire

// File: rtl/aes_inv_mixcol_col_wddl.sv
// ============================================================================
// Module  : aes_inv_mixcol_col_wddl
// Combinational dual-rail InvMixColumns of one column; zero in gives zero out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_mixcol_col_wddl
  import aes_wddl_pkg::*;
(
  input  logic [31:0] a_p,
  input  logic [31:0] a_n,
  output logic [31:0] b_p,
  output logic [31:0] b_n
);

  dr_byte_t a  [4];
  dr_byte_t x2 [4];
  dr_byte_t x4 [4];
  dr_byte_t x8 [4];
  dr_byte_t m9 [4];
  dr_byte_t mb [4];
  dr_byte_t md [4];
  dr_byte_t me [4];
  dr_byte_t b  [4];

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_byte
    assign a[i].p = a_p[31-8*i -: 8];
    assign a[i].n = a_n[31-8*i -: 8];
    assign x2[i]  = dr_xtime(a[i]);
    assign x4[i]  = dr_xtime(x2[i]);
    assign x8[i]  = dr_xtime(x4[i]);
    assign m9[i]  = dr_xor(x8[i], a[i]);
    assign mb[i]  = dr_xor(m9[i], x2[i]);
    assign md[i]  = dr_xor(m9[i], x4[i]);
    assign me[i]  = dr_xor(dr_xor(x8[i], x4[i]), x2[i]);
  end

  // Row r uses coefficients 0e,0b,0d,09 rotated right by r.
  for (genvar r = 0; r < NUM_COLS; r++) begin : g_row
    assign b[r] = dr_xor(dr_xor(me[r], mb[(r+1)%4]),
                         dr_xor(md[(r+2)%4], m9[(r+3)%4]));
    assign b_p[31-8*r -: 8] = b[r].p;
    assign b_n[31-8*r -: 8] = b[r].n;
  end

endmodule

`default_nettype wire

// File: rtl/aes_inv_mixcolumns_wddl_seq.sv
// ============================================================================
// Module  : aes_inv_mixcolumns_wddl_seq
// Iterative WDDL InvMixColumns, one column per evaluate with precharge between.
// Optional rail checker enabled by defining WDDL_RAIL_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_mixcolumns_wddl_seq
  import aes_wddl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  aes_inv_mixcolumns_wddl_seq_if.slave  bus,
  output logic                          err
);

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] in_p_q, in_p_d, in_n_q, in_n_d;
  logic [127:0] res_p_q, res_p_d, res_n_q, res_n_d;
  logic [31:0]  col_in_p, col_in_n, col_out_p, col_out_n;

  // Operands stay at zero on both rails unless evaluating.
  always_comb begin
    col_in_p = '0;
    col_in_n = '0;
    if (state_q == EVAL) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (col_q == c[1:0]) begin
          col_in_p = in_p_q[127-32*c -: 32];
          col_in_n = in_n_q[127-32*c -: 32];
        end
      end
    end
  end

  aes_inv_mixcol_col_wddl u_col (
    .a_p (col_in_p),
    .a_n (col_in_n),
    .b_p (col_out_p),
    .b_n (col_out_n)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_p_d  = in_p_q;
    in_n_d  = in_n_q;
    res_p_d = res_p_q;
    res_n_d = res_n_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          in_p_d  = bus.in_p;
          in_n_d  = bus.in_n;
          col_d   = 2'd0;
          res_p_d = '0;
          res_n_d = '0;
          state_d = PRE;
        end
      end
      PRE: state_d = EVAL;
      EVAL: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (col_q == c[1:0]) begin
            res_p_d[127-32*c -: 32] = col_out_p;
            res_n_d[127-32*c -: 32] = col_out_n;
          end
        end
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end else begin
          col_d   = col_q + 2'd1;
          state_d = PRE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      in_p_q  <= '0;
      in_n_q  <= '0;
      res_p_q <= '0;
      res_n_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_p_q  <= in_p_d;
      in_n_q  <= in_n_d;
      res_p_q <= res_p_d;
      res_n_q <= res_n_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_p     = res_p_q;
  assign bus.out_n     = res_n_q;

`ifdef WDDL_RAIL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && bus.in_valid && ((bus.in_p ^ bus.in_n) != '1)) err_d = 1'b1;
    if ((state_q == EVAL) && ((col_out_p ^ col_out_n) != '1)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_mixcolumns_wddl_seq.sv
// ============================================================================
// Module  : tb_aes_inv_mixcolumns_wddl_seq
// Scoreboard bench for the iterative dual-rail InvMixColumns engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_inv_mixcolumns_wddl_seq;

  typedef struct {
    logic [127:0] exp;
    bit           chk;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  sb_item_t sb_q[$];

`ifdef WDDL_RAIL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [127:0] V_BASIC  = {4{32'h8e4da1bc}};
  localparam logic [127:0] E_BASIC  = {4{32'hdb135345}};
  localparam logic [127:0] V_MIXED  = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
  localparam logic [127:0] E_MIXED  = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345};

  aes_inv_mixcolumns_wddl_seq_if bus ();

  aes_inv_mixcolumns_wddl_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected item per completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 128'd1, 128'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        if (it.chk) begin
          check("out_p", bus.out_p, it.exp);
          check("out_n", bus.out_n, ~it.exp);
        end
      end
    end
  end

  task automatic send(input logic [127:0] p, input logic [127:0] n,
                      input bit push, input bit chk, input logic [127:0] exp,
                      output int acc);
    bit done = 0;
    acc = -1;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_n     = n;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1;
        if (push) sb_q.push_back('{exp: exp, chk: chk});
        #1;
        acc = cyc;
      end else begin
        step();
      end
    end
    bus.in_valid = 1'b0;
    if (!done) check("accept_timeout", 128'd1, 128'd0);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.in_ready && sb_q.size() == 0) done = 1;
      else step();
    end
    if (!done) check("drain_timeout", 128'd1, 128'd0);
  endtask

  task automatic wait_out_valid();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.out_valid) done = 1;
      else step();
    end
    if (!done) check("out_valid_timeout", 128'd1, 128'd0);
  endtask

  initial begin
    int acc_a, acc_b, acc_c;
    logic [127:0] bad_n;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_n      = '0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("rst_out_p", bus.out_p, 128'd0);
    check("rst_out_n", bus.out_n, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    rst = 1'b0;
    step();

    // Basic block with latency and single-cycle out_valid
    send(V_BASIC, ~V_BASIC, 1, 1, E_BASIC, acc_a);
    repeat (7) step();
    check("lat_before_done", {127'd0, bus.out_valid}, 128'd0);
    step();
    check("lat_at_done", {127'd0, bus.out_valid}, 128'd1);
    step();
    check("out_valid_one_cycle", {127'd0, bus.out_valid}, 128'd0);
    wait_idle();

    // Mixed columns, precharge operands zero in every PRE cycle
    send(V_MIXED, ~V_MIXED, 1, 1, E_MIXED, acc_a);
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        check("pre_op_p", {96'd0, dut.col_in_p}, 128'd0);
        check("pre_op_n", {96'd0, dut.col_in_n}, 128'd0);
      end
      step();
    end
    wait_idle();

    // Backpressure with an ignored in_valid pulse
    bus.out_ready = 1'b0;
    send(V_BASIC, ~V_BASIC, 1, 1, E_BASIC, acc_a);
    wait_out_valid();
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", {127'd0, bus.out_valid}, 128'd1);
      check("bp_out_p", bus.out_p, E_BASIC);
      check("bp_out_n", bus.out_n, ~E_BASIC);
      check("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
      if (i == 5) begin
        bus.in_valid = 1'b1;
        bus.in_p     = V_MIXED;
        bus.in_n     = ~V_MIXED;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("release_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("release_out_valid", {127'd0, bus.out_valid}, 128'd0);
    send(V_MIXED, ~V_MIXED, 1, 1, E_MIXED, acc_b);
    send(V_BASIC, ~V_BASIC, 1, 1, E_BASIC, acc_c);
    check("accept_spacing", 128'(acc_c - acc_b), 128'd10);
    wait_idle();

    // Reset during EVAL1 drops the block
    send(V_MIXED, ~V_MIXED, 0, 0, '0, acc_a);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("mid_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("mid_rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("mid_rst_out_p", bus.out_p, 128'd0);
    check("mid_rst_out_n", bus.out_n, 128'd0);
    rst = 1'b0;
    step();
    send(V_MIXED, ~V_MIXED, 1, 1, E_MIXED, acc_a);
    wait_idle();

    // Rail violation on bit 5
    bad_n    = ~V_BASIC;
    bad_n[5] = V_BASIC[5];
    send(V_BASIC, bad_n, 1, 0, '0, acc_a);
    check("err_after_accept", {127'd0, err}, {127'd0, EXP_ERR});
    wait_idle();
    send(V_MIXED, ~V_MIXED, 1, 1, E_MIXED, acc_a);
    wait_idle();
    check("err_sticky", {127'd0, err}, {127'd0, EXP_ERR});
    rst = 1'b1;
    step();
    check("err_cleared", {127'd0, err}, 128'd0);
    rst = 1'b0;
    step();

    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
